// File: rtl/sc_pkg.sv
// sc_pkg
// Shared constants and helper functions for the match serializer.
//   N_CH_DEFAULT / TIME_W_DEFAULT : default lane count and time width
//   SAT_MAX_W                     : widest time value sat_diff handles
//   lane_w()                      : width of a lane index for n lanes
//   sat_diff()                    : signed, symmetric-saturating a - b
package sc_pkg;

    localparam int N_CH_DEFAULT   = 37;
    localparam int TIME_W_DEFAULT = 16;
    localparam int SAT_MAX_W      = 32;

    // A single lane still needs a one-bit index so port widths never collapse to zero.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Both operands are unsigned w-bit times carried in SAT_MAX_W bits. The
    // difference is clamped symmetrically to +/-(2^(w-1)-1), so the most negative
    // w-bit code never appears and the lower w bits of the result are the answer.
    function automatic logic [SAT_MAX_W-1:0] sat_diff(input logic [SAT_MAX_W-1:0] a,
                                                      input logic [SAT_MAX_W-1:0] b,
                                                      input int w);
        longint diff;
        longint lim;
        diff = longint'({32'd0, a}) - longint'({32'd0, b});
        lim  = (longint'(1) <<< (w - 1)) - longint'(1);
        if (diff > lim) begin
            diff = lim;
        end else if (diff < -lim) begin
            diff = -lim;
        end
        return SAT_MAX_W'(diff);
    endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// sc_rr_arbiter
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping modulo N. The owner keeps and advances the pointer.
//   req         : one request bit per lane
//   ptr         : lane where the search starts (must be < N)
//   en          : arbitration enable; no grant when low
//   grant_valid : a request was granted
//   grant_idx   : index of the granted lane
module sc_rr_arbiter
    import sc_pkg::*;
#(
    parameter int N    = N_CH_DEFAULT,
    parameter int CH_W = lane_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant_idx
);

    // Walk the lanes starting at ptr; the first hit wins and later hits are ignored.
    always_comb begin
        int s;
        logic [CH_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        s           = 0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) begin
                s = s - N;
            end
            idx = CH_W'(s);
            if (en && !grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/sc_match_serializer.sv
// sc_match_serializer
// Collects per-lane match triggers into one-deep slots and issues them one at a
// time, round-robin, over a valid/ready stream with a saturated timing error.
//   clk, rst       : clock, synchronous active-high reset
//   song_time      : current song time (unsigned ticks)
//   match_trigger  : one-cycle pulse per lane
//   match_time     : lane i scheduled time at [i*TIME_W +: TIME_W]
//   out_valid/out_ready/out_ch/out_dt : event stream to scoring logic
//   pending        : number of occupied lane slots (output register excluded)
//   drop_pulse     : one-cycle pulse after a trigger was lost
//   drop_count     : saturating count of lost triggers
module sc_match_serializer
    import sc_pkg::*;
#(
    parameter int N_CH   = N_CH_DEFAULT,
    parameter int TIME_W = TIME_W_DEFAULT,
    parameter int CH_W   = lane_w(N_CH),
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TIME_W-1:0]        song_time,
    input  logic [N_CH-1:0]          match_trigger,
    input  logic [N_CH*TIME_W-1:0]   match_time,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [TIME_W-1:0]        out_dt,
    output logic [CH_W:0]            pending,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_count
);

    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   pend_next;
    logic [N_CH-1:0]   issue_vec;
    logic [N_CH-1:0]   capture;
    logic [N_CH-1:0]   drop_vec;
    logic [TIME_W-1:0] slot_time [N_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic              load;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W:0]     drop_n;
    logic [CH_W:0]     pend_cnt_next;
    logic [CNT_W:0]    drop_sum;

    // The output register can take a new event when it is empty or being consumed.
    assign load = !out_valid || out_ready;

    sc_rr_arbiter #(
        .N    (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req         (pend),
        .ptr         (rr_ptr),
        .en          (load),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A slot being issued this cycle frees up in time to accept a same-cycle
    // trigger, so only triggers on slots that stay full count as drops.
    always_comb begin
        issue_vec = '0;
        if (grant_valid) begin
            issue_vec[grant_idx] = 1'b1;
        end
        capture       = match_trigger & (~pend | issue_vec);
        drop_vec      = match_trigger & pend & ~issue_vec;
        pend_next     = (pend & ~issue_vec) | capture;
        drop_n        = '0;
        pend_cnt_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            drop_n        = drop_n + (CH_W+1)'(drop_vec[i]);
            pend_cnt_next = pend_cnt_next + (CH_W+1)'(pend_next[i]);
        end
        drop_sum = (CNT_W+1)'(drop_count) + (CNT_W+1)'(drop_n);
    end

    // Control state, output register and accounting. dt is computed from the
    // song time at issue, not at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            rr_ptr     <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_dt     <= '0;
            pending    <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            pend       <= pend_next;
            pending    <= pend_cnt_next;
            drop_pulse <= |drop_vec;
            drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (load) begin
                if (grant_valid) begin
                    out_valid <= 1'b1;
                    out_ch    <= grant_idx;
                    out_dt    <= TIME_W'(sat_diff(SAT_MAX_W'(song_time),
                                                  SAT_MAX_W'(slot_time[grant_idx]),
                                                  TIME_W));
                    rr_ptr    <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Slot times carry no reset; they are only meaningful while pend is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (capture[i] && !rst) begin
                slot_time[i] <= match_time[i*TIME_W +: TIME_W];
            end
        end
    end

endmodule

// File: tb/tb_sc_match_serializer.sv
// tb_sc_match_serializer
// Self-checking bench for sc_match_serializer: a hand-computed vector table,
// directed multi-cycle sequences, and randomized traffic against a
// cycle-level behavioural model of the event queue.
module tb_sc_match_serializer;

    localparam int N   = 37;
    localparam int TW  = 16;
    localparam int CW  = $clog2(N);
    localparam int CNT = 16;

    logic              clk;
    logic              rst;
    logic [TW-1:0]     song_time;
    logic [N-1:0]      match_trigger;
    logic [N*TW-1:0]   match_time;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_ch;
    logic [TW-1:0]     out_dt;
    logic [CW:0]       pending;
    logic              drop_pulse;
    logic [CNT-1:0]    drop_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_pend [N];
    int m_time [N];
    int m_ptr;
    bit m_valid;
    int m_ch;
    int m_dt;
    int m_drops;
    bit m_dpulse;
    int m_pending;

    typedef struct {
        bit            rst;
        logic [15:0]   song;
        int            lane;
        logic [15:0]   mt;
        bit            ready;
        bit            ev;
        int            ech;
        logic [15:0]   edt;
        int            epend;
    } vec_t;

    vec_t vecs [16];

    sc_match_serializer #(
        .N_CH   (N),
        .TIME_W (TW),
        .CH_W   (CW),
        .CNT_W  (CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .song_time     (song_time),
        .match_trigger (match_trigger),
        .match_time    (match_time),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ch        (out_ch),
        .out_dt        (out_dt),
        .pending       (pending),
        .drop_pulse    (drop_pulse),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of the model: issue from the queue of occupied lanes in
    // circular order, then absorb this cycle's triggers.
    task automatic model_step();
        int g;
        int d;
        int drops;
        int cnt;
        bit ld;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_time[i] = 0;
            end
            m_ptr = 0; m_valid = 1'b0; m_ch = 0; m_dt = 0;
            m_drops = 0; m_dpulse = 1'b0; m_pending = 0;
            return;
        end
        ld = !m_valid || out_ready;
        g = -1;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) begin
            d = int'(song_time) - m_time[g];
            if (d > 32767) d = 32767;
            if (d < -32767) d = -32767;
            m_valid = 1'b1; m_ch = g; m_dt = d;
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % N;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if (match_trigger[i]) begin
                if (m_pend[i]) begin
                    drops++;
                end else begin
                    m_pend[i] = 1'b1;
                    m_time[i] = int'(match_time[i*TW +: TW]);
                end
            end
        end
        m_drops  = (m_drops + drops > 65535) ? 65535 : m_drops + drops;
        m_dpulse = (drops > 0);
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(m_pend[i]);
        m_pending = cnt;
    endtask

    task automatic check_model();
        logic [15:0] edt;
        edt = m_dt[15:0];
        check_output("model_valid", out_valid, m_valid);
        check_output("model_ch", out_ch, m_ch);
        check_output("model_dt", out_dt, edt);
        check_output("model_pending", pending, m_pending);
        check_output("model_drop_pulse", drop_pulse, m_dpulse);
        check_output("model_drop_count", drop_count, m_drops);
    endtask

    // Advance one clock, check against the model just after the edge, then
    // release the one-cycle trigger pulses.
    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        match_trigger = '0;
    endtask

    task automatic trig(input int lane, input logic [15:0] t);
        match_trigger[lane] = 1'b1;
        match_time[lane*TW +: TW] = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
    endtask

    initial begin
        int got [$];
        int bad;

        rst = 1'b1; song_time = '0; match_trigger = '0; match_time = '0; out_ready = 1'b1;

        //          rst    song       lane mt          rdy   ev    ch  dt         pend
        vecs[0]  = '{1'b1, 16'd0,     -1,  16'd0,      1'b1, 1'b0, 0,  16'h0000,  0};
        vecs[1]  = '{1'b0, 16'd110,   0,   16'd107,    1'b1, 1'b0, 0,  16'h0000,  1};
        vecs[2]  = '{1'b0, 16'd110,   -1,  16'd0,      1'b1, 1'b1, 0,  16'h0003,  0};
        vecs[3]  = '{1'b0, 16'd110,   -1,  16'd0,      1'b1, 1'b0, 0,  16'h0003,  0};
        vecs[4]  = '{1'b0, 16'd0,     7,   16'd40000,  1'b1, 1'b0, 0,  16'h0003,  1};
        vecs[5]  = '{1'b0, 16'd0,     -1,  16'd0,      1'b1, 1'b1, 7,  16'h8001,  0};
        vecs[6]  = '{1'b0, 16'd65535, 8,   16'd0,      1'b1, 1'b0, 7,  16'h8001,  1};
        vecs[7]  = '{1'b0, 16'd65535, -1,  16'd0,      1'b1, 1'b1, 8,  16'h7FFF,  0};
        vecs[8]  = '{1'b0, 16'd100,   9,   16'd100,    1'b1, 1'b0, 8,  16'h7FFF,  1};
        vecs[9]  = '{1'b0, 16'd100,   -1,  16'd0,      1'b1, 1'b1, 9,  16'h0000,  0};
        vecs[10] = '{1'b0, 16'd5,     10,  16'd6,      1'b1, 1'b0, 9,  16'h0000,  1};
        vecs[11] = '{1'b0, 16'd5,     -1,  16'd0,      1'b1, 1'b1, 10, 16'hFFFF,  0};
        vecs[12] = '{1'b0, 16'd0,     11,  16'd32768,  1'b1, 1'b0, 10, 16'hFFFF,  1};
        vecs[13] = '{1'b0, 16'd0,     -1,  16'd0,      1'b1, 1'b1, 11, 16'h8001,  0};
        vecs[14] = '{1'b0, 16'd32767, 12,  16'd0,      1'b1, 1'b0, 11, 16'h8001,  1};
        vecs[15] = '{1'b0, 16'd32767, -1,  16'd0,      1'b1, 1'b1, 12, 16'h7FFF,  0};

        for (int v = 0; v < 16; v++) begin
            rst       = vecs[v].rst;
            song_time = vecs[v].song;
            out_ready = vecs[v].ready;
            if (vecs[v].lane >= 0) trig(vecs[v].lane, vecs[v].mt);
            apply_stimulus();
            check_output($sformatf("vec%0d_valid", v), out_valid, vecs[v].ev);
            check_output($sformatf("vec%0d_ch", v), out_ch, vecs[v].ech);
            check_output($sformatf("vec%0d_dt", v), out_dt, vecs[v].edt);
            check_output($sformatf("vec%0d_pending", v), pending, vecs[v].epend);
        end
        rst = 1'b0;

        // Fairness: three lanes at once, twice, pointer wraps past lane 36.
        do_reset();
        out_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            got.delete();
            trig(3, 16'd1); trig(10, 16'd2); trig(36, 16'd3);
            apply_stimulus();
            for (int c = 0; c < 6; c++) begin
                apply_stimulus();
                if (out_valid) got.push_back(int'(out_ch));
            end
            check_output("fair_count", got.size(), 3);
            if (got.size() == 3) begin
                check_output("fair_first", got[0], 3);
                check_output("fair_second", got[1], 10);
                check_output("fair_third", got[2], 36);
            end
        end

        // Backpressure: lane 1 held in the output, lane 2 waits in its slot.
        do_reset();
        out_ready = 1'b0;
        trig(1, 16'd0); trig(2, 16'd0);
        apply_stimulus();
        check_output("bp_pending2", pending, 2);
        apply_stimulus();
        check_output("bp_first_ch", out_ch, 1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            apply_stimulus();
            if (!out_valid || out_ch != 1 || pending != 1) bad++;
        end
        check_output("bp_stable", bad, 0);
        out_ready = 1'b1;
        apply_stimulus();
        check_output("bp_next_valid", out_valid, 1);
        check_output("bp_next_ch", out_ch, 2);

        // Drop: second trigger on an occupied lane is lost, first time kept.
        do_reset();
        out_ready = 1'b0;
        song_time = 16'd1000;
        trig(0, 16'd50);
        apply_stimulus();
        apply_stimulus();
        check_output("drop_hold_ch", out_ch, 0);
        trig(5, 16'd200);
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        trig(5, 16'd300);
        apply_stimulus();
        check_output("drop_pulse_hi", drop_pulse, 1);
        check_output("drop_count_1", drop_count, 1);
        apply_stimulus();
        check_output("drop_pulse_lo", drop_pulse, 0);
        out_ready = 1'b1;
        apply_stimulus();
        check_output("drop_issue_ch", out_ch, 5);
        check_output("drop_issue_dt", out_dt, 16'd800);

        // Reset mid-operation with full slots, a held event and a nonzero drop count.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) trig(i, 16'(i * 10));
        apply_stimulus();
        apply_stimulus();
        check_output("rmid_pending4", pending, 4);
        trig(1, 16'd77);
        apply_stimulus();
        check_output("rmid_drop_before", drop_count, 1);
        rst = 1'b1;
        trig(6, 16'd1); trig(7, 16'd2);
        apply_stimulus();
        rst = 1'b0;
        check_output("rmid_valid", out_valid, 0);
        check_output("rmid_pending", pending, 0);
        check_output("rmid_drops", drop_count, 0);
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus();
            if (out_valid) bad++;
        end
        check_output("rmid_no_issue", bad, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            song_time = 16'($urandom);
            rst       = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) trig(i, 16'($urandom));
            end
            apply_stimulus();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
